// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion, default sizes and the pointer type.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int ADDR_W_DEF      = 7;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int PTR_W_DEF       = ADDR_W_DEF + 1;

    typedef logic [PTR_W_DEF-1:0] ptr_t;

    // Callers zero-extend into 32 bits and size-cast the result back to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int width);
        logic [31:0] g;
        g = b ^ (b >> 1);
        if (width < 32) begin
            g = g & ((32'd1 << width) - 32'd1);
        end
        return g;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
        logic [31:0] b;
        b = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        if (width < 32) begin
            b = b & ((32'd1 << width) - 32'd1);
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
// Synchronous active-low reset clears every stage.
module ptr_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_d;
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/r_ptr_empty_ctrl.sv
// Read-side pointer, empty, fill-level and underflow controller for the async FIFO.
// Define R_ALMOST_EMPTY_EN to add the registered almost_empty flag (threshold AE_THRESH).
module r_ptr_empty_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int AE_THRESH   = 4
) (
    input  logic              r_clk,
    input  logic              n_rst,
    input  logic              r_en,
    input  logic [ADDR_W:0]   w_gray_async,
    output logic [ADDR_W:0]   rptr,
    output logic [ADDR_W-1:0] r_addr,
    output logic              empty,
    output logic [ADDR_W:0]   r_level,
`ifdef R_ALMOST_EMPTY_EN
    output logic              almost_empty,
`endif
    output logic              underflow
);

    localparam int PTR_W = ADDR_W + 1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || AE_THRESH < 0) begin : g_bad_param
        $error("r_ptr_empty_ctrl: SYNC_STAGES must be 2..4 and AE_THRESH non-negative");
    end

    logic [PTR_W-1:0] w_sync;
    logic [PTR_W-1:0] w_bin_sync;
    logic             rd_ok;

    logic [PTR_W-1:0] r_bin_d,     r_bin_q;
    logic [PTR_W-1:0] rptr_d,      rptr_q;
    logic [PTR_W-1:0] level_d,     level_q;
    logic             empty_d,     empty_q;
    logic             underflow_d, underflow_q;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_w_sync (
        .clk   (r_clk),
        .n_rst (n_rst),
        .d     (w_gray_async),
        .q     (w_sync)
    );

    // Status flags are judged against the post-read pointer so a read this cycle is already accounted for.
    always_comb begin
        rd_ok       = r_en & ~empty_q;
        r_bin_d     = r_bin_q + PTR_W'(rd_ok);
        rptr_d      = PTR_W'(bin2gray(32'(r_bin_d), PTR_W));
        w_bin_sync  = PTR_W'(gray2bin(32'(w_sync), PTR_W));
        level_d     = w_bin_sync - r_bin_d;
        empty_d     = (rptr_d == w_sync);
        underflow_d = r_en & empty_q;
    end

    always_ff @(posedge r_clk) begin
        if (!n_rst) begin
            r_bin_q     <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            r_bin_q     <= r_bin_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef R_ALMOST_EMPTY_EN
    logic almost_empty_d, almost_empty_q;

    always_comb begin
        almost_empty_d = (level_d <= PTR_W'(AE_THRESH));
    end

    always_ff @(posedge r_clk) begin
        if (!n_rst) begin
            almost_empty_q <= 1'b1;
        end else begin
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_empty = almost_empty_q;
`endif

    assign rptr      = rptr_q;
    assign r_addr    = r_bin_q[ADDR_W-1:0];
    assign empty     = empty_q;
    assign r_level   = level_q;
    assign underflow = underflow_q;

endmodule
